// File: rtl/di_arb_pkg.sv
// -----------------------------------------------------------------------------
// di_arb_pkg
// Shared types and constants for the DI register bus arbiter.
//   arb_state_e : arbiter FSM states (IDLE, SETTLE, ACTIVE)
//   M0 / M1     : master index constants (m0 = host side, m1 = sequencer)
//   DEF_*       : default parameter values used by the top level
//   other_master: returns the index of the opposite master
// -----------------------------------------------------------------------------
package di_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACTIVE = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int DEF_ADDR_W        = 16;
   localparam int DEF_DATA_W        = 16;
   localparam int DEF_SETTLE_CYCLES = 2;
   localparam int DEF_TIMEOUT       = 255;

   function automatic logic other_master(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/di_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// di_arb_rr_pick
// Two-way round-robin picker. A master is eligible when it requests and is
// not locked out. With a single eligible master it wins outright; with two,
// the one that did not own the bus last wins.
// Ports:
//   req[1:0]     in  : request per master
//   last_owner   in  : master that held the previous burst
//   lockout[1:0] in  : per-master grant inhibit
//   valid        out : at least one eligible master
//   winner       out : index of the selected master
// -----------------------------------------------------------------------------
module di_arb_rr_pick
   import di_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic [1:0] lockout,
   output logic       valid,
   output logic       winner
);

   logic [1:0] elig_s;

   // Eligibility mask and winner selection.
   always_comb begin
      elig_s = req & ~lockout;
      valid  = |elig_s;
      case (elig_s)
         2'b01:   winner = M0;
         2'b10:   winner = M1;
         2'b11:   winner = other_master(last_owner);
         default: winner = M0;
      endcase
   end

endmodule

// File: rtl/di_bus_arbiter.sv
// -----------------------------------------------------------------------------
// di_bus_arbiter
// Shares the DI register bus between m0 (HostInterface side) and m1 (on-chip
// sequencer). Whole bursts are granted round-robin. After every grant the new
// owner's address is driven for SETTLE_CYCLES cycles with strobes and ready
// suppressed, because the terminals register rdwr_ready from the address.
// Optional feature (macro DI_BUS_ARBITER_TIMEOUT_EN): a not-ready watchdog
// forces a release after TIMEOUT cycles, raises sticky timeout_err and locks
// the offending master out until it drops its request for a cycle.
// Ports:
//   clk, reset               : single clock, synchronous active-high reset
//   mN_req / mN_gnt          : burst request / registered grant (N = 0, 1)
//   mN_ep_addr, mN_reg_addr  : master addresses
//   mN_data_in, mN_write,
//   mN_read                  : master write data and strobes
//   mN_data_out,
//   mN_rdwr_ready            : read data / ready back to the master
//   di_*                     : bus to the endpoint terminals
//   timeout_err              : sticky watchdog flag (0 without the feature)
// -----------------------------------------------------------------------------
module di_bus_arbiter
   import di_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   output logic              m0_gnt,
   input  logic [ADDR_W-1:0] m0_ep_addr,
   input  logic [ADDR_W-1:0] m0_reg_addr,
   input  logic [DATA_W-1:0] m0_data_in,
   input  logic              m0_write,
   input  logic              m0_read,
   output logic [DATA_W-1:0] m0_data_out,
   output logic              m0_rdwr_ready,
   input  logic              m1_req,
   output logic              m1_gnt,
   input  logic [ADDR_W-1:0] m1_ep_addr,
   input  logic [ADDR_W-1:0] m1_reg_addr,
   input  logic [DATA_W-1:0] m1_data_in,
   input  logic              m1_write,
   input  logic              m1_read,
   output logic [DATA_W-1:0] m1_data_out,
   output logic              m1_rdwr_ready,
   output logic [ADDR_W-1:0] di_ep_addr,
   output logic [ADDR_W-1:0] di_reg_addr,
   output logic [DATA_W-1:0] di_reg_data_in,
   output logic              di_write,
   output logic              di_read,
   input  logic [DATA_W-1:0] di_reg_data_out,
   input  logic              di_rdwr_ready,
   output logic              timeout_err
);

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic [2:0]        settle_cnt_q, settle_cnt_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [ADDR_W-1:0] hold_ep_q, hold_ep_d;
   logic [ADDR_W-1:0] hold_reg_q, hold_reg_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;

   logic [1:0]        req_vec;
   logic [1:0]        lockout_s;
   logic              pick_valid;
   logic              pick_winner;

   logic              own_req;
   logic              own_read;
   logic              own_write;
   logic [ADDR_W-1:0] own_ep;
   logic [ADDR_W-1:0] own_reg;
   logic [DATA_W-1:0] own_data;
   logic              busy;
   logic              active;

`ifdef DI_BUS_ARBITER_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [1:0]  lockout_q, lockout_d;
   logic        timeout_err_q, timeout_err_d;

   assign lockout_s = lockout_q;
`else
   assign lockout_s = 2'b00;
`endif

   assign req_vec = {m1_req, m0_req};

   di_arb_rr_pick u_pick (
      .req        (req_vec),
      .last_owner (last_owner_q),
      .lockout    (lockout_s),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   // Select the current owner's request, strobes, addresses and write data.
   always_comb begin
      if (owner_q == M1) begin
         own_req   = m1_req;
         own_read  = m1_read;
         own_write = m1_write;
         own_ep    = m1_ep_addr;
         own_reg   = m1_reg_addr;
         own_data  = m1_data_in;
      end else begin
         own_req   = m0_req;
         own_read  = m0_read;
         own_write = m0_write;
         own_ep    = m0_ep_addr;
         own_reg   = m0_reg_addr;
         own_data  = m0_data_in;
      end
   end

   // Next-state logic for the arbiter FSM and its bookkeeping registers.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      settle_cnt_d = settle_cnt_q;
      gnt_d        = gnt_q;
      hold_ep_d    = hold_ep_q;
      hold_reg_d   = hold_reg_q;
      hold_data_d  = hold_data_q;
`ifdef DI_BUS_ARBITER_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      // A lockout survives only while its master keeps requesting.
      lockout_d     = lockout_q & req_vec;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d      = pick_winner;
               gnt_d        = (pick_winner == M1) ? 2'b10 : 2'b01;
               settle_cnt_d = 3'd0;
               state_d      = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            // Track what is on the bus so IDLE can keep driving it.
            hold_ep_d   = own_ep;
            hold_reg_d  = own_reg;
            hold_data_d = own_data;
`ifdef DI_BUS_ARBITER_TIMEOUT_EN
            tmo_cnt_d = 16'd0;
`endif
            if (!own_req) begin
               state_d      = IDLE;
               gnt_d        = 2'b00;
               last_owner_d = owner_q;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               state_d      = ACTIVE;
               settle_cnt_d = settle_cnt_q + 3'd1;
            end else begin
               settle_cnt_d = settle_cnt_q + 3'd1;
            end
         end
         ACTIVE: begin
            hold_ep_d   = own_ep;
            hold_reg_d  = own_reg;
            hold_data_d = own_data;
            if (!own_req) begin
               state_d      = IDLE;
               gnt_d        = 2'b00;
               last_owner_d = owner_q;
            end else begin
`ifdef DI_BUS_ARBITER_TIMEOUT_EN
               if (di_rdwr_ready) begin
                  tmo_cnt_d = 16'd0;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  // Terminal never answered: force the bus free.
                  state_d            = IDLE;
                  gnt_d              = 2'b00;
                  last_owner_d       = owner_q;
                  timeout_err_d      = 1'b1;
                  lockout_d[owner_q] = 1'b1;
                  tmo_cnt_d          = 16'd0;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 16'd1;
               end
`else
               state_d = ACTIVE;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   // State and bookkeeping flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= M0;
         last_owner_q <= M1;
         settle_cnt_q <= 3'd0;
         gnt_q        <= 2'b00;
         hold_ep_q    <= '0;
         hold_reg_q   <= '0;
         hold_data_q  <= '0;
`ifdef DI_BUS_ARBITER_TIMEOUT_EN
         tmo_cnt_q     <= 16'd0;
         lockout_q     <= 2'b00;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         settle_cnt_q <= settle_cnt_d;
         gnt_q        <= gnt_d;
         hold_ep_q    <= hold_ep_d;
         hold_reg_q   <= hold_reg_d;
         hold_data_q  <= hold_data_d;
`ifdef DI_BUS_ARBITER_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         lockout_q     <= lockout_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   // Bus and master-side outputs; strobes and ready pass through only in ACTIVE.
   always_comb begin
      busy   = (state_q != IDLE);
      active = (state_q == ACTIVE);

      m0_gnt = gnt_q[0];
      m1_gnt = gnt_q[1];

      if (busy) begin
         di_ep_addr     = own_ep;
         di_reg_addr    = own_reg;
         di_reg_data_in = own_data;
      end else begin
         di_ep_addr     = hold_ep_q;
         di_reg_addr    = hold_reg_q;
         di_reg_data_in = hold_data_q;
      end

      di_read  = active & own_read;
      di_write = active & own_write;

      m0_rdwr_ready = 1'b0;
      m1_rdwr_ready = 1'b0;
      m0_data_out   = '0;
      m1_data_out   = '0;
      if (active && (owner_q == M1)) begin
         m1_rdwr_ready = di_rdwr_ready;
         m1_data_out   = di_reg_data_out;
      end else if (active) begin
         m0_rdwr_ready = di_rdwr_ready;
         m0_data_out   = di_reg_data_out;
      end else begin
         m0_rdwr_ready = 1'b0;
         m1_rdwr_ready = 1'b0;
      end

`ifdef DI_BUS_ARBITER_TIMEOUT_EN
      timeout_err = timeout_err_q;
`else
      timeout_err = 1'b0;
`endif
   end

endmodule

// File: tb/tb_di_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_di_bus_arbiter
// Self-checking bench for di_bus_arbiter: a directed vector table, hand-written
// multi-cycle sequences (tie after reset, IDLE gap, read data routing, reset
// mid-burst, burst alternation, optional watchdog) and a randomized run, all
// compared every cycle against a burst-level reference model.
// -----------------------------------------------------------------------------
module tb_di_bus_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int SET = 2;
`ifdef DI_BUS_ARBITER_TIMEOUT_EN
   localparam int TO    = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          m0_req, m1_req;
   logic          m0_gnt, m1_gnt;
   logic [AW-1:0] m0_ep_addr, m0_reg_addr, m1_ep_addr, m1_reg_addr;
   logic [DW-1:0] m0_data_in, m1_data_in;
   logic          m0_write, m0_read, m1_write, m1_read;
   logic [DW-1:0] m0_data_out, m1_data_out;
   logic          m0_rdwr_ready, m1_rdwr_ready;
   logic [AW-1:0] di_ep_addr, di_reg_addr;
   logic [DW-1:0] di_reg_data_in;
   logic          di_write, di_read;
   logic [DW-1:0] di_reg_data_out;
   logic          di_rdwr_ready;
   logic          timeout_err;

   di_bus_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(SET), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_ep_addr(m0_ep_addr),
      .m0_reg_addr(m0_reg_addr), .m0_data_in(m0_data_in), .m0_write(m0_write),
      .m0_read(m0_read), .m0_data_out(m0_data_out), .m0_rdwr_ready(m0_rdwr_ready),
      .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_ep_addr(m1_ep_addr),
      .m1_reg_addr(m1_reg_addr), .m1_data_in(m1_data_in), .m1_write(m1_write),
      .m1_read(m1_read), .m1_data_out(m1_data_out), .m1_rdwr_ready(m1_rdwr_ready),
      .di_ep_addr(di_ep_addr), .di_reg_addr(di_reg_addr),
      .di_reg_data_in(di_reg_data_in), .di_write(di_write), .di_read(di_read),
      .di_reg_data_out(di_reg_data_out), .di_rdwr_ready(di_rdwr_ready),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (burst level) ----------------
   bit            m_busy;
   int            m_own, m_last, m_age, m_cnt;
   bit            m_terr;
   bit [1:0]      m_lock;
   logic [AW-1:0] m_hep, m_hreg;
   logic [DW-1:0] m_hdat;

   function automatic bit req_of(input int i);
      return (i == 1) ? m1_req : m0_req;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_own = 0; m_last = 1; m_age = 0; m_cnt = 0;
      m_terr = 1'b0; m_lock = 2'b00; m_hep = '0; m_hreg = '0; m_hdat = '0;
   endtask

   task automatic model_step();
      bit [1:0] e;
      bit [1:0] nlock;
      if (reset) begin
         model_reset();
      end else begin
         e     = {m1_req & ~m_lock[1], m0_req & ~m_lock[0]};
         nlock = m_lock & {m1_req, m0_req};
         if (!m_busy) begin
            if (e != 2'b00) begin
               m_own  = (e == 2'b11) ? (1 - m_last) : (e[1] ? 1 : 0);
               m_busy = 1'b1; m_age = 0; m_cnt = 0;
            end
         end else begin
            m_hep  = m_own ? m1_ep_addr  : m0_ep_addr;
            m_hreg = m_own ? m1_reg_addr : m0_reg_addr;
            m_hdat = m_own ? m1_data_in  : m0_data_in;
            if (!req_of(m_own)) begin
               m_busy = 1'b0; m_last = m_own;
            end else if (TO_EN && m_age >= SET && !di_rdwr_ready && m_cnt == TO - 1) begin
               m_busy = 1'b0; m_last = m_own; m_terr = 1'b1; nlock[m_own] = 1'b1;
            end else begin
               if (m_age >= SET) m_cnt = di_rdwr_ready ? 0 : m_cnt + 1;
               m_age++;
            end
         end
         m_lock = nlock;
      end
   endtask

   task automatic check_model();
      bit act;
      act = m_busy && (m_age >= SET);
      chk("mdl_gnt0", m0_gnt, m_busy && m_own == 0);
      chk("mdl_gnt1", m1_gnt, m_busy && m_own == 1);
      chk("mdl_di_read",  di_read,  act && (m_own ? m1_read  : m0_read));
      chk("mdl_di_write", di_write, act && (m_own ? m1_write : m0_write));
      chk("mdl_di_ep",  di_ep_addr,  m_busy ? (m_own ? m1_ep_addr  : m0_ep_addr)  : m_hep);
      chk("mdl_di_reg", di_reg_addr, m_busy ? (m_own ? m1_reg_addr : m0_reg_addr) : m_hreg);
      chk("mdl_di_din", di_reg_data_in, m_busy ? (m_own ? m1_data_in : m0_data_in) : m_hdat);
      chk("mdl_rdy0", m0_rdwr_ready, (act && m_own == 0) ? di_rdwr_ready : 1'b0);
      chk("mdl_rdy1", m1_rdwr_ready, (act && m_own == 1) ? di_rdwr_ready : 1'b0);
      chk("mdl_dout0", m0_data_out, (act && m_own == 0) ? di_reg_data_out : 16'h0000);
      chk("mdl_dout1", m1_data_out, (act && m_own == 1) ? di_reg_data_out : 16'h0000);
      chk("mdl_terr", timeout_err, m_terr);
   endtask

   // ---------------- cycle helpers ----------------
   task automatic mid();
      #4;
      check_model();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         mid();
         edge_step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          req;
      bit          rd;
      bit          rdy;
      bit          e_gnt;
      bit          e_rd;
      bit          e_rdy;
      logic [15:0] e_ep;
   } vec_t;

   vec_t vt[7];

   initial begin
      reset = 1'b1;
      m0_req = 1'b0; m1_req = 1'b0;
      m0_ep_addr = '0; m0_reg_addr = '0; m0_data_in = '0; m0_write = 1'b0; m0_read = 1'b0;
      m1_ep_addr = '0; m1_reg_addr = '0; m1_data_in = '0; m1_write = 1'b0; m1_read = 1'b0;
      di_reg_data_out = '0; di_rdwr_ready = 1'b0;

      @(posedge clk);
      #1;
      model_reset();
      // Reset state.
      mid();
      chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("rst_strobes", {di_read, di_write}, 2'b00);
      chk("rst_ep", di_ep_addr, 16'h0000);
      chk("rst_terr", timeout_err, 1'b0);
      edge_step();
      reset = 1'b0;

      // m0 alone: grant after 1 cycle, two settle cycles, then pass-through.
      vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001};
      vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001};
      vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001};
      vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001};
      vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
      m0_ep_addr  = 16'h0001;
      m0_reg_addr = 16'h0010;
      for (int i = 0; i < 7; i++) begin
         m0_req        = vt[i].req;
         m0_read       = vt[i].rd;
         di_rdwr_ready = vt[i].rdy;
         mid();
         chk($sformatf("tbl_gnt[%0d]", i), m0_gnt, vt[i].e_gnt);
         chk($sformatf("tbl_read[%0d]", i), di_read, vt[i].e_rd);
         chk($sformatf("tbl_rdy[%0d]", i), m0_rdwr_ready, vt[i].e_rdy);
         chk($sformatf("tbl_ep[%0d]", i), di_ep_addr, vt[i].e_ep);
         edge_step();
      end

      // Tie after reset: m0 first, then m1 after one IDLE cycle.
      do_reset();
      m0_req = 1'b1; m1_req = 1'b1;
      m1_ep_addr = 16'h0002; m1_reg_addr = 16'h0020;
      cyc(1);
      mid();
      chk("tie_m0_gnt", m0_gnt, 1'b1);
      chk("tie_m1_gnt", m1_gnt, 1'b0);
      edge_step();
      cyc(1);
      m0_req = 1'b0;
      cyc(1);
      mid();
      chk("gap_idle", {m1_gnt, m0_gnt}, 2'b00);
      edge_step();
      mid();
      chk("m1_after_gap", m1_gnt, 1'b1);
      edge_step();
      cyc(1);
      // m1 ACTIVE read returns terminal data only to m1.
      m1_read = 1'b1; di_reg_data_out = 16'hBEEF; di_rdwr_ready = 1'b1;
      mid();
      chk("m1_dout", m1_data_out, 16'hBEEF);
      chk("m0_dout_zero", m0_data_out, 16'h0000);
      chk("m0_rdy_zero", m0_rdwr_ready, 1'b0);
      chk("m1_rdy", m1_rdwr_ready, 1'b1);
      chk("m1_di_read", di_read, 1'b1);
      edge_step();
      m1_req = 1'b0; m1_read = 1'b0;
      cyc(2);

      // Continuous requests alternate per burst.
      m0_req = 1'b1; m1_req = 1'b1;
      for (int b = 0; b < 4; b++) begin
         int w;
         w = -1;
         for (int k = 0; k < 8 && w < 0; k++) begin
            mid();
            if (m0_gnt) w = 0;
            else if (m1_gnt) w = 1;
            else edge_step();
         end
         chk($sformatf("burst_order[%0d]", b), w, b % 2);
         edge_step();
         cyc(2);
         if (w == 0) m0_req = 1'b0;
         else if (w == 1) m1_req = 1'b0;
         cyc(1);
         m0_req = 1'b1; m1_req = 1'b1;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      cyc(2);

      // Reset mid-burst: m0 finishes one burst (last owner m0), then a
      // second m0 burst is aborted by reset; m0 must still win the next tie.
      m0_req = 1'b1;
      cyc(4);
      m0_req = 1'b0;
      cyc(2);
      m0_req = 1'b1; m0_read = 1'b1;
      cyc(3);
      mid();
      chk("pre_rst_read", di_read, 1'b1);
      edge_step();
      reset = 1'b1;
      cyc(1);
      mid();
      chk("rst_mid_read", di_read, 1'b0);
      chk("rst_mid_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("rst_mid_ep", di_ep_addr, 16'h0000);
      chk("rst_mid_reg", di_reg_addr, 16'h0000);
      edge_step();
      reset = 1'b0; m1_req = 1'b1;
      cyc(1);
      mid();
      chk("rst_tie_m0", m0_gnt, 1'b1);
      edge_step();
      m0_req = 1'b0; m1_req = 1'b0; m0_read = 1'b0;
      cyc(3);

`ifdef DI_BUS_ARBITER_TIMEOUT_EN
      // Watchdog: 8 not-ready ACTIVE cycles force a release and lockout.
      do_reset();
      di_rdwr_ready = 1'b0; m0_req = 1'b1;
      cyc(3 + TO);
      mid();
      chk("tmo_gnt_drop", m0_gnt, 1'b0);
      chk("tmo_err", timeout_err, 1'b1);
      edge_step();
      for (int i = 0; i < 4; i++) begin
         mid();
         chk($sformatf("tmo_lockout[%0d]", i), m0_gnt, 1'b0);
         edge_step();
      end
      m0_req = 1'b0;
      cyc(1);
      m0_req = 1'b1;
      cyc(1);
      mid();
      chk("tmo_regrant", m0_gnt, 1'b1);
      chk("tmo_err_sticky", timeout_err, 1'b1);
      edge_step();
      m0_req = 1'b0; di_rdwr_ready = 1'b1;
      cyc(2);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (m0_req) m0_req = ($urandom_range(0, 5) != 0);
         else        m0_req = ($urandom_range(0, 2) == 0);
         if (m1_req) m1_req = ($urandom_range(0, 5) != 0);
         else        m1_req = ($urandom_range(0, 2) == 0);
         m0_ep_addr  = 16'($urandom); m0_reg_addr = 16'($urandom);
         m1_ep_addr  = 16'($urandom); m1_reg_addr = 16'($urandom);
         m0_data_in  = 16'($urandom); m1_data_in  = 16'($urandom);
         m0_read  = $urandom_range(0, 1) != 0; m0_write = $urandom_range(0, 1) != 0;
         m1_read  = $urandom_range(0, 1) != 0; m1_write = $urandom_range(0, 1) != 0;
         di_reg_data_out = 16'($urandom);
         di_rdwr_ready   = TO_EN ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
         reset = ($urandom_range(0, 499) == 0);
         cyc(1);
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
